// File: rtl/helix_ctrl_packet_encoder.sv
// ============================================================================
// helix_ctrl_packet_encoder
//
// Purpose : Transmit-side encoder for HELIX control packets. Takes one command
//           (type, 22-bit address, 16-bit data) over valid/ready. Emits it as a
//           4-beat, byte-swapped AXI4-Stream packet in this order:
//             B0 header
//             B1 SOF/type/addr-high
//             B2 addr-low/data-high
//             B3 data-low/EOF
//
// Build option:
//   HELIX_ENC_BACK2BACK_EN  When defined, a command can also be accepted on the
//                           B3 handshake, so packets stream with no idle cycle
//                           (4 cycles/packet). When undefined, commands are
//                           accepted only in IDLE (5 cycles/packet).
//
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   s_cmd_type[1:0]   00 NOP, 01 WRITE, 10 READ, 11 UPDATE
//   s_cmd_addr[21:0]  address ([21:12] = lane/board/chip)
//   s_cmd_data[15:0]  write data
//   s_cmd_valid/ready command handshake
//   m_axis_tdata[15:0] stream word, byte [7:0] first on the wire
//   m_axis_tuser[1:0] [0] header beat flag, [1] always 0
//   m_axis_tlast      high on beat B3
//   m_axis_tvalid/tready stream handshake
//   busy_o            packet latched and not fully sent
//   pkt_count_o[15:0] completed packets, wrapping
// ============================================================================
module helix_ctrl_packet_encoder (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [1:0]  s_cmd_type,
    input  logic [21:0] s_cmd_addr,
    input  logic [15:0] s_cmd_data,
    input  logic        s_cmd_valid,
    output logic        s_cmd_ready,
    output logic [15:0] m_axis_tdata,
    output logic [1:0]  m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy_o,
    output logic [15:0] pkt_count_o
);

    localparam logic [15:0] HEADER = 16'hC751;
    localparam logic [3:0]  SOF    = 4'hF;
    localparam logic [3:0]  EOF    = 4'h8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_B3   = 3'd4
    } state_t;

    state_t      r_state;
    logic [1:0]  r_type;
    logic [21:0] r_addr;
    logic [15:0] r_data;
    logic [15:0] r_tdata;
    logic [1:0]  r_tuser;
    logic        r_tlast;
    logic        r_tvalid;
    logic [15:0] r_pkt_count;
    logic        r_rdy_en;

    logic        w_hs;
    logic        w_ready;
    logic        w_accept;

    // Header word is sent byte-swapped so its low byte leads on the wire.
    localparam logic [15:0] HEADER_WORD = {HEADER[7:0], HEADER[15:8]};

    // Payload word for beats B1..B3 built from the captured command fields.
    function automatic logic [15:0] beat_word(
        input state_t      st,
        input logic [1:0]  t,
        input logic [21:0] a,
        input logic [15:0] d
    );
        logic [15:0] w;
        w = 16'h0000;
        case (st)
            ST_B0:   w = HEADER_WORD;
            ST_B1:   w = {a[19:12], SOF, t, a[21:20]};
            ST_B2:   w = {a[3:0], d[15:12], a[11:4]};
            ST_B3:   w = {d[3:0], EOF, d[11:4]};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    assign w_hs = r_tvalid & m_axis_tready;

    // r_rdy_en holds ready low while reset is asserted and for the first edge after it.
`ifdef HELIX_ENC_BACK2BACK_EN
    assign w_ready = r_rdy_en & ((r_state == ST_IDLE) |
                                 ((r_state == ST_B3) & m_axis_tready));
`else
    assign w_ready = r_rdy_en & (r_state == ST_IDLE);
`endif

    assign w_accept = s_cmd_valid & w_ready;

    // Packet sequencer. The next beat is loaded on each handshake, so all stream outputs are registered.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_type      <= 2'b00;
            r_addr      <= 22'd0;
            r_data      <= 16'h0000;
            r_tdata     <= 16'h0000;
            r_tuser     <= 2'b00;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_pkt_count <= 16'h0000;
            r_rdy_en    <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_type   <= s_cmd_type;
                        r_addr   <= s_cmd_addr;
                        r_data   <= s_cmd_data;
                        r_tdata  <= HEADER_WORD;
                        r_tuser  <= 2'b01;
                        r_tlast  <= 1'b0;
                        r_tvalid <= 1'b1;
                        r_state  <= ST_B0;
                    end
                end
                ST_B0: begin
                    if (w_hs) begin
                        r_tdata <= beat_word(ST_B1, r_type, r_addr, r_data);
                        r_tuser <= 2'b00;
                        r_state <= ST_B1;
                    end
                end
                ST_B1: begin
                    if (w_hs) begin
                        r_tdata <= beat_word(ST_B2, r_type, r_addr, r_data);
                        r_state <= ST_B2;
                    end
                end
                ST_B2: begin
                    if (w_hs) begin
                        r_tdata <= beat_word(ST_B3, r_type, r_addr, r_data);
                        r_tlast <= 1'b1;
                        r_state <= ST_B3;
                    end
                end
                ST_B3: begin
                    if (w_hs) begin
                        r_pkt_count <= r_pkt_count + 16'd1;
                        // w_accept can only be true here when back-to-back acceptance is built in.
                        if (w_accept) begin
                            r_type  <= s_cmd_type;
                            r_addr  <= s_cmd_addr;
                            r_data  <= s_cmd_data;
                            r_tdata <= HEADER_WORD;
                            r_tuser <= 2'b01;
                            r_tlast <= 1'b0;
                            r_state <= ST_B0;
                        end else begin
                            r_tdata  <= 16'h0000;
                            r_tuser  <= 2'b00;
                            r_tlast  <= 1'b0;
                            r_tvalid <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_tvalid <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_cmd_ready   = w_ready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;
    assign busy_o        = (r_state != ST_IDLE);
    assign pkt_count_o   = r_pkt_count;

endmodule
